// File: rtl/zigzag_rle_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : zigzag_rle_encoder
//  Purpose  : Accepts an 8x8 block of quantized coefficients and emits
//             JPEG-style run/value symbols in zigzag order. The symbol
//             sequence is DC, then AC run/value pairs with ZRL (16 zeros)
//             and end-of-block symbols inserted where they are needed.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1          rising-edge clock
//    rst_n      in   1          asynchronous active-low reset
//    blk_valid  in   1          block on blk_data is valid
//    blk_data   in   64*DATA_W  coefficient (r,c) at [(r*8+c)*DATA_W +: DATA_W]
//    blk_ready  out  1          encoder idle, block can be accepted
//    sym_valid  out  1          symbol on sym_* is valid
//    sym_ready  in   1          downstream accepts the symbol
//    sym_run    out  4          zero-run length preceding sym_value
//    sym_value  out  DATA_W     signed coefficient value
//    sym_dc     out  1          symbol is the DC coefficient
//    sym_eob    out  1          symbol is end-of-block
// ============================================================================
module zigzag_rle_encoder #(
   parameter int DATA_W = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 blk_valid,
   input  logic [64*DATA_W-1:0] blk_data,
   output logic                 blk_ready,
   output logic                 sym_valid,
   input  logic                 sym_ready,
   output logic [3:0]           sym_run,
   output logic [DATA_W-1:0]    sym_value,
   output logic                 sym_dc,
   output logic                 sym_eob
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_ZRL  = 2'd2,
      ST_EOB  = 2'd3
   } state_t;

   // Zigzag position -> raster position (row*8 + col)
   localparam logic [5:0] ZZ_TO_RASTER [64] = '{
       6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
       6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
       6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
       6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
       6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
       6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
       6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
       6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
   };

   localparam logic [5:0] IDX_LAST  = 6'd63;
   localparam logic [5:0] RUN_ZRL   = 6'd16;
   localparam logic [5:0] RUN_TWO_Z = 6'd32;

   state_t              state;
   state_t              state_nxt;
   logic [5:0]          idx;
   logic [5:0]          idx_nxt;
   logic [5:0]          run;
   logic [5:0]          run_nxt;
   logic [DATA_W-1:0]   buffer [64];
   logic [DATA_W-1:0]   coef;
   logic                accept;

   assign coef   = buffer[ZZ_TO_RASTER[idx]];
   assign accept = blk_valid & blk_ready;

   // Coefficient buffer: only written on block acceptance
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 64; i++) begin
            buffer[i] <= '0;
         end
      end else if (accept) begin
         for (int i = 0; i < 64; i++) begin
            buffer[i] <= blk_data[i*DATA_W +: DATA_W];
         end
      end
   end

   // State, zigzag index and zero-run registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         idx   <= '0;
         run   <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
         run   <= run_nxt;
      end
   end

   // Next-state and output decode. Symbol outputs depend only on registered
   // state and buffer contents, so they remain stable during a stall.
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      run_nxt   = run;
      blk_ready = 1'b0;
      sym_valid = 1'b0;
      sym_run   = 4'd0;
      sym_value = '0;
      sym_dc    = 1'b0;
      sym_eob   = 1'b0;

      case (state)
         ST_IDLE: begin
            blk_ready = 1'b1;
            if (blk_valid) begin
               state_nxt = ST_SCAN;
               idx_nxt   = '0;
               run_nxt   = '0;
            end
         end

         ST_SCAN: begin
            if (idx == 6'd0) begin
               sym_valid = 1'b1;
               sym_dc    = 1'b1;
               sym_value = coef;
               if (sym_ready) begin
                  idx_nxt = 6'd1;
               end
            end else if (coef == '0) begin
               // Silent zero: accumulate the run, one coefficient per cycle
               run_nxt = run + 6'd1;
               idx_nxt = idx + 6'd1;
               if (idx == IDX_LAST) begin
                  state_nxt = ST_EOB;
               end
            end else if (run >= RUN_ZRL) begin
               // Run too long for one symbol: drain 16-zero chunks first
               state_nxt = ST_ZRL;
            end else begin
               sym_valid = 1'b1;
               sym_run   = run[3:0];
               sym_value = coef;
               if (sym_ready) begin
                  run_nxt = '0;
                  idx_nxt = idx + 6'd1;
                  if (idx == IDX_LAST) begin
                     state_nxt = ST_IDLE;
                  end
               end
            end
         end

         ST_ZRL: begin
            sym_valid = 1'b1;
            sym_run   = 4'd15;
            if (sym_ready) begin
               run_nxt = run - RUN_ZRL;
               // Remaining run is below 16 exactly when the current run is below 32
               if (run < RUN_TWO_Z) begin
                  state_nxt = ST_SCAN;
               end
            end
         end

         ST_EOB: begin
            sym_valid = 1'b1;
            sym_eob   = 1'b1;
            if (sym_ready) begin
               state_nxt = ST_IDLE;
            end
         end

         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_zigzag_rle_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_zigzag_rle_encoder
//  Purpose  : Self-checking bench for zigzag_rle_encoder. Blocks are encoded
//             by a queue-based reference model and compared symbol by symbol.
//  Revision : 1.0  initial release
// ============================================================================
module tb_zigzag_rle_encoder;

   localparam int DW = 16;

   typedef struct {
      logic [3:0]    run;
      logic [DW-1:0] value;
      logic          dc;
      logic          eob;
   } sym_t;

   logic               clk;
   logic               rst_n;
   logic               blk_valid;
   logic [64*DW-1:0]   blk_data;
   logic               blk_ready;
   logic               sym_valid;
   logic               sym_ready;
   logic [3:0]         sym_run;
   logic [DW-1:0]      sym_value;
   logic               sym_dc;
   logic               sym_eob;

   int                 n_cmp;
   int                 n_err;
   logic [DW-1:0]      cur_blk [64];
   int                 zz_map [64];
   sym_t               exp_q [$];

   zigzag_rle_encoder #(.DATA_W(DW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .blk_valid (blk_valid),
      .blk_data  (blk_data),
      .blk_ready (blk_ready),
      .sym_valid (sym_valid),
      .sym_ready (sym_ready),
      .sym_run   (sym_run),
      .sym_value (sym_value),
      .sym_dc    (sym_dc),
      .sym_eob   (sym_eob)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic sym_t mk(input int r, input logic [DW-1:0] v, input logic d, input logic e);
      sym_t s;
      s.run   = 4'(r);
      s.value = v;
      s.dc    = d;
      s.eob   = e;
      return s;
   endfunction

   // Zigzag walk along anti-diagonals: odd diagonals go down-left, even up-right
   task automatic build_zigzag();
      int k;
      k = 0;
      for (int s = 0; s < 15; s++) begin
         int lo;
         int hi;
         lo = (s > 7) ? s - 7 : 0;
         hi = (s < 7) ? s : 7;
         if (s % 2 == 1) begin
            for (int r = lo; r <= hi; r++) begin
               zz_map[k] = r * 8 + (s - r);
               k++;
            end
         end else begin
            for (int r = hi; r >= lo; r--) begin
               zz_map[k] = r * 8 + (s - r);
               k++;
            end
         end
      end
   endtask

   task automatic build_expected();
      int run;
      exp_q.delete();
      exp_q.push_back(mk(0, cur_blk[0], 1'b1, 1'b0));
      run = 0;
      for (int z = 1; z < 64; z++) begin
         logic [DW-1:0] v;
         v = cur_blk[zz_map[z]];
         if (v == '0) begin
            run++;
         end else begin
            while (run >= 16) begin
               exp_q.push_back(mk(15, '0, 1'b0, 1'b0));
               run -= 16;
            end
            exp_q.push_back(mk(run, v, 1'b0, 1'b0));
            run = 0;
         end
      end
      if (run > 0) exp_q.push_back(mk(0, '0, 1'b0, 1'b1));
   endtask

   task automatic clear_blk();
      for (int i = 0; i < 64; i++) cur_blk[i] = '0;
   endtask

   // Waits for blk_ready and presents cur_blk for one cycle. Returns 0 on timeout.
   task automatic accept_block(input string name, output bit ok);
      int n;
      n = 0;
      while (blk_ready !== 1'b1 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      n_cmp++;
      if (blk_ready !== 1'b1) begin
         n_err++;
         $display("FAIL %s accept: blk_ready=%b required 1 within 20 cycles", name, blk_ready);
         ok = 1'b0;
         return;
      end
      for (int i = 0; i < 64; i++) blk_data[i*DW +: DW] = cur_blk[i];
      blk_valid = 1'b1;
      @(posedge clk); #1;
      blk_valid = 1'b0;
      ok = 1'b1;
   endtask

   // mode 0: sym_ready always 1; mode 1: random; mode 2: 5-cycle stall on DC/ZRL
   task automatic run_block(input int mode, input string name);
      int   cycles;
      int   stall_cnt;
      bit   prev_stall;
      bit   hs;
      bit   ok;
      logic [3:0]    h_run;
      logic [DW-1:0] h_val;
      logic          h_dc;
      logic          h_eob;
      sym_t f;
      build_expected();
      accept_block(name, ok);
      if (!ok) return;
      cycles     = 0;
      stall_cnt  = 0;
      prev_stall = 1'b0;
      h_run = '0; h_val = '0; h_dc = 1'b0; h_eob = 1'b0;
      while (exp_q.size() > 0 && cycles < 2000) begin
         // Junk block offers while busy must be ignored
         blk_valid = 1'($urandom_range(0, 1));
         for (int i = 0; i < 64; i++) blk_data[i*DW +: DW] = DW'($urandom);
         n_cmp++;
         if (blk_ready !== 1'b0) begin
            n_err++;
            $display("FAIL %s busy_ready: blk_ready=%b required 0", name, blk_ready);
         end
         f = exp_q[0];
         if (sym_valid === 1'b1) begin
            if (mode == 2 && !prev_stall && (f.dc || (f.run == 4'd15 && !f.eob && f.value == '0)))
               stall_cnt = 5;
            if (mode == 0)      sym_ready = 1'b1;
            else if (mode == 1) sym_ready = 1'($urandom_range(0, 1));
            else                sym_ready = (stall_cnt > 0) ? 1'b0 : 1'b1;
            if (stall_cnt > 0) stall_cnt--;
            n_cmp++;
            if (sym_run !== f.run || sym_value !== f.value || sym_dc !== f.dc || sym_eob !== f.eob) begin
               n_err++;
               $display("FAIL %s symbol: got run=%0d val=%0d dc=%b eob=%b required run=%0d val=%0d dc=%b eob=%b",
                        name, sym_run, $signed(sym_value), sym_dc, sym_eob,
                        f.run, $signed(f.value), f.dc, f.eob);
            end
            if (prev_stall) begin
               n_cmp++;
               if (sym_run !== h_run || sym_value !== h_val || sym_dc !== h_dc || sym_eob !== h_eob) begin
                  n_err++;
                  $display("FAIL %s stall_hold: got run=%0d val=%0d dc=%b eob=%b required run=%0d val=%0d dc=%b eob=%b",
                           name, sym_run, $signed(sym_value), sym_dc, sym_eob,
                           h_run, $signed(h_val), h_dc, h_eob);
               end
            end
         end else begin
            sym_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            n_cmp++;
            if (prev_stall || sym_run !== 4'd0 || sym_value !== '0 || sym_dc !== 1'b0 || sym_eob !== 1'b0) begin
               n_err++;
               $display("FAIL %s idle_outputs: valid=%b run=%0d val=%0d dc=%b eob=%b required zeros (dropped=%b)",
                        name, sym_valid, sym_run, $signed(sym_value), sym_dc, sym_eob, prev_stall);
            end
         end
         hs         = (sym_valid === 1'b1) && (sym_ready === 1'b1);
         prev_stall = (sym_valid === 1'b1) && (sym_ready === 1'b0);
         h_run = sym_run; h_val = sym_value; h_dc = sym_dc; h_eob = sym_eob;
         @(posedge clk); #1;
         if (hs) void'(exp_q.pop_front());
         cycles++;
      end
      blk_valid = 1'b0;
      sym_ready = 1'b0;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL %s timeout: %0d symbols outstanding required 0", name, exp_q.size());
      end
      n_cmp++;
      if (blk_ready !== 1'b1 || sym_valid !== 1'b0) begin
         n_err++;
         $display("FAIL %s block_end: blk_ready=%b sym_valid=%b required 1 and 0", name, blk_ready, sym_valid);
      end
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      blk_valid = 1'b0;
      blk_data  = '0;
      sym_ready = 1'b0;
      #3;
      n_cmp++;
      if (blk_ready !== 1'b1 || sym_valid !== 1'b0 || sym_run !== 4'd0 || sym_value !== '0 ||
          sym_dc !== 1'b0 || sym_eob !== 1'b0) begin
         n_err++;
         $display("FAIL reset_state: ready=%b valid=%b run=%0d val=%0d dc=%b eob=%b required 1,0,0,0,0,0",
                  blk_ready, sym_valid, sym_run, sym_value, sym_dc, sym_eob);
      end
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_directed();
      clear_blk();
      run_block(0, "all_zero");
      clear_blk();
      cur_blk[0] = DW'(100);
      cur_blk[1] = DW'(-5);
      run_block(0, "dc100_ac_m5");
      clear_blk();
      cur_blk[zz_map[40]] = DW'(7);
      run_block(0, "zz40_two_zrl");
      clear_blk();
      cur_blk[0]  = DW'(1);
      cur_blk[63] = DW'(3);
      run_block(0, "last_coef_no_eob");
      clear_blk();
      cur_blk[0]  = 16'h8000;
      cur_blk[2]  = 16'h7fff;
      cur_blk[63] = 16'hffff;
      run_block(1, "extreme_values");
   endtask

   task automatic test_backpressure();
      clear_blk();
      cur_blk[zz_map[40]] = DW'(7);
      run_block(2, "stall_dc_zrl");
      clear_blk();
      cur_blk[0]  = DW'(1);
      cur_blk[63] = DW'(3);
      run_block(2, "stall_three_zrl");
   endtask

   task automatic test_random();
      for (int b = 0; b < 24; b++) begin
         int dens;
         dens = (b % 4 == 0) ? 60 : (b % 4 == 1) ? 15 : (b % 4 == 2) ? 3 : 100;
         for (int i = 0; i < 64; i++) begin
            if ($urandom_range(0, 99) < dens) cur_blk[i] = DW'($urandom);
            else                              cur_blk[i] = '0;
         end
         run_block(b % 3, "random");
      end
   endtask

   task automatic test_back_to_back();
      for (int b = 0; b < 4; b++) begin
         clear_blk();
         cur_blk[0] = DW'(b);
         cur_blk[zz_map[$urandom_range(1, 63)]] = DW'($urandom_range(1, 500));
         run_block(0, "back_to_back");
      end
   endtask

   task automatic test_reset_midblock();
      int  hs_cnt;
      int  n;
      bit  ok;
      clear_blk();
      cur_blk[0] = DW'(100);
      cur_blk[1] = DW'(-5);
      accept_block("mid_reset", ok);
      if (!ok) return;
      hs_cnt    = 0;
      n         = 0;
      sym_ready = 1'b1;
      while (hs_cnt < 2 && n < 50) begin
         if (sym_valid === 1'b1) hs_cnt++;
         @(posedge clk); #1;
         n++;
      end
      n_cmp++;
      if (hs_cnt != 2) begin
         n_err++;
         $display("FAIL mid_reset handshakes: got %0d required 2", hs_cnt);
      end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (sym_valid !== 1'b0 || blk_ready !== 1'b1 || sym_eob !== 1'b0) begin
         n_err++;
         $display("FAIL mid_reset immediate: valid=%b ready=%b eob=%b required 0,1,0",
                  sym_valid, blk_ready, sym_eob);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if (sym_valid !== 1'b0 || blk_ready !== 1'b1) begin
         n_err++;
         $display("FAIL mid_reset after_release: valid=%b ready=%b required 0,1", sym_valid, blk_ready);
      end
      clear_blk();
      run_block(1, "post_reset_zero");
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      build_zigzag();
      test_reset();
      test_directed();
      test_backpressure();
      test_back_to_back();
      test_random();
      test_reset_midblock();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/zigzag_rle_encoder.md
ZIGZAG_RLE_ENCODER -- requirements
Module: zigzag_rle_encoder

Interface
REQ-001 SHALL have parameter DATA_W, default 16, the signed width of each quantized coefficient.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port blk_valid  input  1  the 8x8 quantized block on blk_data is valid.
REQ-005 SHALL have port blk_data  input  64*DATA_W  quantized coefficients; row r, column c (0..7) at bits [(r*8+c)*DATA_W +: DATA_W], two's complement.
REQ-006 SHALL have port blk_ready  output  1  the block can be accepted; equals 1 exactly in IDLE.
REQ-007 SHALL have port sym_valid  output  1  the symbol on sym_* is valid.
REQ-008 SHALL have port sym_ready  input  1  the downstream entropy coder accepts the symbol.
REQ-009 SHALL have port sym_run  output  4  zero-run length preceding sym_value.
REQ-010 SHALL have port sym_value  output  DATA_W  coefficient value, signed.
REQ-011 SHALL have port sym_dc  output  1  the symbol is the DC coefficient.
REQ-012 SHALL have port sym_eob  output  1  the symbol is end-of-block.

Function
REQ-013 SHALL accept a block on a cycle with blk_valid=1 and blk_ready=1, latching all 64 coefficients into an internal buffer; blk_data is ignored at all other times.
REQ-014 SHALL scan the buffer in the standard JPEG zigzag order (ITU-T T.81): zz index 0..63 maps to raster index 0,1,8,16,9,2,3,10,17,24,...,61,54,47,55,62,63.
REQ-015 SHALL implement the states IDLE, SCAN, ZRL and EOB, plus a 6-bit zz index counter and a 6-bit zero-run counter.
REQ-016 SHALL move from IDLE to SCAN on acceptance, with idx=0 and run=0; the DC symbol is presented with sym_valid=1 on the next cycle.
REQ-017 In SCAN at idx=0, SHALL present run=0, value=coefficient, sym_dc=1, and on handshake set idx=1.
REQ-018 In SCAN at idx>0 with a zero coefficient, SHALL hold sym_valid=0, increment run and idx in one cycle, and go to EOB when idx=63.
REQ-019 In SCAN at idx>0 with a nonzero coefficient and run>=16, SHALL go to ZRL without advancing idx.
REQ-020 In ZRL, SHALL present run=15, value=0, sym_dc=0, sym_eob=0; on handshake run decreases by 16; return to SCAN when the new run is <16, otherwise remain in ZRL.
REQ-021 In SCAN at idx>0 with a nonzero coefficient and run<16, SHALL present run and value; on handshake clear run and increment idx; when idx=63, go to IDLE with no EOB emitted.
REQ-022 In EOB, SHALL present run=0, value=0, sym_eob=1; on handshake go to IDLE.
REQ-023 Handshake SHALL occur only when sym_valid=1 and sym_ready=1; while sym_valid=1 and sym_ready=0, all sym_* outputs SHALL hold stable.
REQ-024 sym_valid SHALL never drop without a handshake; the sym_ready value SHALL have no effect while sym_valid=0.
REQ-025 When neither DC, ZRL nor EOB is being emitted, sym_dc and sym_eob SHALL be 0, and sym_run, sym_value, sym_dc and sym_eob SHALL be 0 whenever sym_valid=0.
REQ-026 A new block SHALL be accepted no earlier than the cycle after the final handshake of the previous block; there is no overlap.
REQ-027 Coefficient values SHALL pass through unmodified at full DATA_W; there is no saturation or sign change.

Reset
REQ-028 While rst_n=0, the state SHALL be IDLE, idx=0, run=0, the buffer cleared, sym_* all 0, and blk_ready=1.
REQ-029 Reset asserted mid-block SHALL abandon the block immediately, with no further symbols; the first block after release is encoded from its DC.

Verification
REQ-030 All-zero block -> DC(run0,val0,dc=1), then EOB; exactly 2 symbols.
REQ-031 DC=100, raster(0,1)=-5, all others 0 -> DC(0,100), (run0,val-5), EOB.
REQ-032 DC=0, only zz index 40 = 7 -> DC(0,0), ZRL, ZRL, (run7,val7), EOB.
REQ-033 DC=1, only raster 63 = 3 -> DC(0,1), ZRL x3, (run14,val3); no EOB; blk_ready=1 on the next cycle.
REQ-034 sym_ready=0 for 5 cycles during the DC and ZRL symbols -> outputs stable each cycle, no symbol lost or duplicated, and blk_ready=0 until the final handshake.
REQ-035 rst_n pulsed low after the 2nd symbol of the REQ-031 block -> sym_valid=0 and blk_ready=1 at once; a new all-zero block then yields DC and EOB only.
